// File: rtl/temp_reg_interface.sv
// -----------------------------------------------------------------------------
// temp_reg_interface
//
// Host-side register interface for a bank of N_CH temperature-sensor channels.
// The host talks over an RS/RW/EN strobe bus with split din/dout. A command
// access (rs=0) reads or loads the 6-bit register pointer. A data access (rs=1)
// reads or writes the register the pointer selects. Read data is registered and
// is qualified by a one-cycle dout_vld pulse.
//
// Register map
//   0x00 STA   {sel, 0, addr_err, ovr[sel], rdy[sel]}  (all zero when sel >= N_CH)
//   0x01 TMPH  0x02 TMPL  0x03 RAWH  0x04 RAWL          (read-only)
//   0x05 CTL   [0] conversion enable, [1] auto-increment, [7:4] channel select
//   0x06-0x07  reserved: read 0, writes ignored
//   0x08..N_REG-1  calibration bytes (read/write)
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   en, rs, rw, din     host bus strobe, data/command select, write flag, write data
//   dout, dout_vld      registered read data and its one-cycle valid pulse
//   smp_vld/raw/tmp     per-channel sample strobe, raw code and converted temperature
//   ctl_o, cal_o        CTL contents and calibration bytes (addr 0x08 in [7:0])
// -----------------------------------------------------------------------------
module temp_reg_interface #(
  parameter int N_CH  = 1,
  parameter int RAW_W = 16,
  parameter int N_CAL = 16,
  parameter int N_REG = 8 + N_CAL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  rs,
  input  logic                  rw,
  input  logic [7:0]            din,
  output logic [7:0]            dout,
  output logic                  dout_vld,
  input  logic [N_CH-1:0]       smp_vld,
  input  logic [N_CH*RAW_W-1:0] smp_raw,
  input  logic [N_CH*RAW_W-1:0] smp_tmp,
  output logic [7:0]            ctl_o,
  output logic [N_CAL*8-1:0]    cal_o
);

  localparam logic [5:0] A_STA     = 6'h00;
  localparam logic [5:0] A_TMPH    = 6'h01;
  localparam logic [5:0] A_TMPL    = 6'h02;
  localparam logic [5:0] A_RAWH    = 6'h03;
  localparam logic [5:0] A_RAWL    = 6'h04;
  localparam logic [5:0] A_CTL     = 6'h05;
  localparam logic [5:0] LAST_ADDR = 6'(N_REG - 1);

  logic [5:0]       ptr_q;
  logic [7:0]       ctl_q;
  logic [7:0]       cal_q [N_CAL];
  logic [RAW_W-1:0] raw_q [N_CH];
  logic [RAW_W-1:0] tmp_q [N_CH];
  logic [N_CH-1:0]  rdy_q;
  logic [N_CH-1:0]  ovr_q;
  logic             addr_err_q;
  logic [7:0]       shd_tmp_q;
  logic [7:0]       shd_raw_q;

  logic             cmd_wr, cmd_rd, data_wr, data_rd;
  logic             ptr_ok;
  logic [3:0]       sel;
  logic             sel_ok, sel_rdy, sel_ovr;
  logic [N_CH-1:0]  sel_hot;
  logic [RAW_W-1:0] sel_tmp, sel_raw;
  logic [7:0]       cal_rd, sta_val, rd_data;
  logic             sta_rd, tmph_rd, tmpl_rd, rawh_rd;
  logic [5:0]       ptr_inc;

  // Bus decode and the read multiplexer. The selected channel is found with a
  // compare loop rather than an array index, so a select value beyond N_CH
  // simply matches nothing and every per-channel field reads as zero.
  always_comb begin
    cmd_wr  = en & ~rs &  rw;
    cmd_rd  = en & ~rs & ~rw;
    data_wr = en &  rs &  rw;
    data_rd = en &  rs & ~rw;

    sel     = ctl_q[7:4];
    ptr_ok  = (ptr_q <= LAST_ADDR);

    sel_hot = '0;
    sel_ok  = 1'b0;
    sel_rdy = 1'b0;
    sel_ovr = 1'b0;
    sel_tmp = '0;
    sel_raw = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (sel == 4'(c)) begin
        sel_hot[c] = 1'b1;
        sel_ok     = 1'b1;
        sel_rdy    = rdy_q[c];
        sel_ovr    = ovr_q[c];
        sel_tmp    = tmp_q[c];
        sel_raw    = raw_q[c];
      end
    end

    cal_rd = '0;
    for (int i = 0; i < N_CAL; i++) begin
      if (ptr_q == 6'(8 + i)) cal_rd = cal_q[i];
    end

    sta_val = sel_ok ? {sel, 1'b0, addr_err_q, sel_ovr, sel_rdy} : 8'h00;

    // Reserved and out-of-range addresses fall through to cal_rd, which is
    // zero whenever the pointer is not on a calibration byte.
    case (ptr_q)
      A_STA:   rd_data = sta_val;
      A_TMPH:  rd_data = sel_tmp[RAW_W-1 -: 8];
      A_TMPL:  rd_data = shd_tmp_q;
      A_RAWH:  rd_data = sel_raw[RAW_W-1 -: 8];
      A_RAWL:  rd_data = shd_raw_q;
      A_CTL:   rd_data = ctl_q;
      default: rd_data = cal_rd;
    endcase

    sta_rd  = data_rd & (ptr_q == A_STA);
    tmph_rd = data_rd & (ptr_q == A_TMPH);
    tmpl_rd = data_rd & (ptr_q == A_TMPL);
    rawh_rd = data_rd & (ptr_q == A_RAWH);

    ptr_inc = (ptr_q == LAST_ADDR) ? 6'd0 : ptr_q + 6'd1;
  end

  // Host-facing state: pointer, CTL, calibration bytes, the read register and
  // the low-byte shadows. A high-byte read snapshots the matching low byte, so
  // the following low-byte read belongs to the same sample even if a new one
  // has landed in between. Auto-increment follows the CTL value in force before
  // this access, so a write that changes CTL[1] applies from the next access.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q      <= '0;
      ctl_q      <= '0;
      dout       <= '0;
      dout_vld   <= 1'b0;
      addr_err_q <= 1'b0;
      shd_tmp_q  <= '0;
      shd_raw_q  <= '0;
      for (int i = 0; i < N_CAL; i++) cal_q[i] <= '0;
    end else begin
      dout_vld <= 1'b0;
      if (cmd_wr) ptr_q <= din[5:0];
      if (cmd_rd) begin
        dout     <= {2'b00, ptr_q};
        dout_vld <= 1'b1;
      end
      if (data_rd) begin
        dout     <= rd_data;
        dout_vld <= 1'b1;
      end
      if ((data_rd | data_wr) && ctl_q[1]) ptr_q <= ptr_inc;
      if (data_wr && ptr_q == A_CTL) ctl_q <= din;
      for (int i = 0; i < N_CAL; i++) begin
        if (data_wr && ptr_q == 6'(8 + i)) cal_q[i] <= din;
      end
      if ((data_rd | data_wr) && !ptr_ok) addr_err_q <= 1'b1;
      else if (sta_rd)                    addr_err_q <= 1'b0;
      if (tmph_rd) shd_tmp_q <= sel_tmp[7:0];
      if (rawh_rd) shd_raw_q <= sel_raw[7:0];
    end
  end

  // Per-channel sample capture and ready/overrun flags. A capture always wins
  // over the host's clearing reads. A capture that coincides with the TMPL read
  // of the same channel counts as the host having consumed the old sample, so
  // it leaves rdy set without raising an overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q <= '0;
      ovr_q <= '0;
      for (int c = 0; c < N_CH; c++) begin
        raw_q[c] <= '0;
        tmp_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (smp_vld[c]) begin
          raw_q[c] <= smp_raw[c*RAW_W +: RAW_W];
          tmp_q[c] <= smp_tmp[c*RAW_W +: RAW_W];
          rdy_q[c] <= 1'b1;
          if (rdy_q[c] && !(tmpl_rd && sel_hot[c])) ovr_q[c] <= 1'b1;
          else if (sta_rd && sel_hot[c])            ovr_q[c] <= 1'b0;
        end else begin
          if (tmpl_rd && sel_hot[c]) rdy_q[c] <= 1'b0;
          if (sta_rd  && sel_hot[c]) ovr_q[c] <= 1'b0;
        end
      end
    end
  end

  // Export CTL and the calibration bytes to the conversion datapath.
  always_comb begin
    ctl_o = ctl_q;
    cal_o = '0;
    for (int i = 0; i < N_CAL; i++) cal_o[i*8 +: 8] = cal_q[i];
  end

endmodule
